// File: rtl/hdu_pkg.sv
// ---------------------------------------------------------------------------
// hdu_pkg
// Shared types and constants for the hazard/stall controller (hdu_sb).
//   shadow_t       : one shadow-pipeline entry {valid, rdwren, rd}
//   PREG_*         : pipeline-register indices (0 = IF/ID ... 3 = MEM/WB)
//   REG_X0         : the hardwired-zero register, never a real dependency
//   SHADOW_BUBBLE  : value loaded into a shadow entry when a bubble is inserted
//   srcHit()       : true when an entry produces a register an ID source reads
// ---------------------------------------------------------------------------
package hdu_pkg;

    typedef struct packed {
        logic       valid;
        logic       rdwren;
        logic [4:0] rd;
    } shadow_t;

    localparam int PREG_IFID  = 0;
    localparam int PREG_IDEX  = 1;
    localparam int PREG_EXMEM = 2;
    localparam int PREG_MEMWB = 3;

    localparam logic [4:0] REG_X0 = 5'd0;

    localparam shadow_t SHADOW_BUBBLE = '{valid: 1'b0, rdwren: 1'b0, rd: REG_X0};

    // A pending write to x0 is discarded by the regfile, and a source that
    // the instruction does not actually read can never create a hazard.
    function automatic logic srcHit(
        input shadow_t    entry,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       rs1Used,
        input logic       rs2Used
    );
        return entry.valid && entry.rdwren && (entry.rd != REG_X0) &&
               ((rs1Used && (entry.rd == rs1)) || (rs2Used && (entry.rd == rs2)));
    endfunction

endpackage

// File: rtl/hdu_sat_cnt.sv
// ---------------------------------------------------------------------------
// hdu_sat_cnt
// Saturating up-counter with synchronous clear; stops at MAX.
// Ports:
//   i_clk    : clock
//   i_reset  : synchronous active-high reset, count returns to 0
//   i_clear  : synchronous clear (lower priority than reset)
//   i_inc    : increment by one unless already at MAX
//   o_count  : current count
// ---------------------------------------------------------------------------
module hdu_sat_cnt #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Count register: clear beats increment, and the value sticks at MAX.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hdu_sb.sv
// ---------------------------------------------------------------------------
// hdu_sb
// Hazard/stall controller for the 5-stage non-forwarding SRAM pipeline.
// Keeps a shadow copy of (valid, rdwren, rd) for every pipeline register
// downstream of IF/ID and stalls the ID instruction while any of the first
// HAZ_DEPTH shadow entries will still write one of its sources. Also handles
// branch/jump redirect flushes, whole-pipe SRAM freezes and an SRAM-stall
// watchdog.
//
// Ports:
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_sram_stall          : LSU/SRAM not ready, freeze the whole pipe
//   i_pcsel               : redirect taken by the instruction at BR_STAGE
//   i_is_br, i_is_uncbr   : that instruction is a branch / jal-jalr
//   i_id_valid            : IF/ID holds a real instruction
//   i_id_rdwren, i_id_rd  : ID destination write enable and register
//   i_id_rs1, i_id_rs2    : ID sources
//   i_id_rs1_used/rs2_used: source is actually read
//   o_pc_wren             : PC write enable
//   o_preg_wren           : per-pipeline-register write enable
//   o_preg_clear          : per-pipeline-register clear (load bubble)
//   o_raw_stall           : RAW stall active this cycle
//   o_sram_timeout        : sticky watchdog flag
//
// Optional feature, macro HDU_PERF_CNT_EN:
//   adds o_cnt_raw, o_cnt_flush, o_cnt_sram saturating performance counters.
// ---------------------------------------------------------------------------
module hdu_sb
    import hdu_pkg::*;
#(
    parameter int N_PREG    = 4,
    parameter int HAZ_DEPTH = 3,
    parameter int BR_STAGE  = 2,
    parameter int TIMEOUT   = 1024,
    parameter int CNT_W     = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_sram_stall,
    input  logic              i_pcsel,
    input  logic              i_is_br,
    input  logic              i_is_uncbr,
    input  logic              i_id_valid,
    input  logic              i_id_rdwren,
    input  logic [4:0]        i_id_rd,
    input  logic [4:0]        i_id_rs1,
    input  logic [4:0]        i_id_rs2,
    input  logic              i_id_rs1_used,
    input  logic              i_id_rs2_used,
    output logic              o_pc_wren,
    output logic [N_PREG-1:0] o_preg_wren,
    output logic [N_PREG-1:0] o_preg_clear,
    output logic              o_raw_stall,
    output logic              o_sram_timeout
`ifdef HDU_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  o_cnt_raw,
    output logic [CNT_W-1:0]  o_cnt_flush,
    output logic [CNT_W-1:0]  o_cnt_sram
`endif
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    shadow_t         r_sh [1:N_PREG-1];
    shadow_t         w_idEntry;
    logic            w_redirect;
    logic            w_raw;
    logic            w_rawStall;
    logic [WD_W-1:0] w_wdCount;
    logic            r_timeout;

    assign w_idEntry = '{valid: i_id_valid, rdwren: i_id_rdwren, rd: i_id_rd};

    // Hazard detection: only entries 1..HAZ_DEPTH matter, deeper producers
    // have already reached the register file by the time ID reads it.
    always_comb begin
        w_redirect = i_pcsel & (i_is_br | i_is_uncbr);
        w_raw      = 1'b0;
        for (int k = 1; k <= HAZ_DEPTH; k++) begin
            if (srcHit(r_sh[k], i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used)) begin
                w_raw = 1'b1;
            end
        end
        w_raw = w_raw & i_id_valid;
    end

    // Pipeline control outputs. An SRAM freeze overrides everything, a
    // redirect flushes the wrong-path instructions (so a RAW on a doomed
    // instruction is ignored), and a RAW stall holds PC and IF/ID while a
    // bubble is loaded into ID/EX.
    always_comb begin
        o_pc_wren    = 1'b1;
        o_preg_wren  = '1;
        o_preg_clear = '0;
        o_raw_stall  = 1'b0;
        if (i_reset) begin
            o_pc_wren    = 1'b0;
            o_preg_clear = '1;
        end else if (i_sram_stall) begin
            o_pc_wren   = 1'b0;
            o_preg_wren = '0;
        end else if (w_redirect) begin
            for (int k = 0; k < N_PREG; k++) begin
                o_preg_clear[k] = (k <= BR_STAGE);
            end
        end else if (w_raw) begin
            o_pc_wren               = 1'b0;
            o_preg_wren[PREG_IFID]  = 1'b0;
            o_preg_clear[PREG_IDEX] = 1'b1;
            o_raw_stall             = 1'b1;
        end
    end

    assign w_rawStall = o_raw_stall;

    // Shadow pipeline: tracks what each pipeline register will hold after
    // this edge, mirroring the bubbles the outputs above insert.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 1; k < N_PREG; k++) begin
                r_sh[k] <= SHADOW_BUBBLE;
            end
        end else if (!i_sram_stall) begin
            r_sh[1] <= (w_redirect || w_raw) ? SHADOW_BUBBLE : w_idEntry;
            for (int k = 2; k < N_PREG; k++) begin
                r_sh[k] <= (w_redirect && (k <= BR_STAGE)) ? SHADOW_BUBBLE : r_sh[k-1];
            end
        end
    end

    // Watchdog: counts consecutive SRAM-stall cycles, any free cycle restarts it.
    hdu_sat_cnt #(
        .WIDTH (WD_W),
        .MAX   (WD_W'(TIMEOUT))
    ) u_watchdog (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (~i_sram_stall),
        .i_inc   (i_sram_stall),
        .o_count (w_wdCount)
    );

    // Timeout flag is set on the same edge the count reaches TIMEOUT, so the
    // flag and the saturated count always appear together; it stays set
    // until reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_timeout <= 1'b0;
        end else if (i_sram_stall && (w_wdCount == WD_W'(TIMEOUT - 1))) begin
            r_timeout <= 1'b1;
        end
    end

    assign o_sram_timeout = r_timeout;

`ifdef HDU_PERF_CNT_EN
    // Performance counters, saturating at all-ones.
    hdu_sat_cnt #(.WIDTH(CNT_W)) u_cntRaw (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (1'b0),
        .i_inc   (w_rawStall),
        .o_count (o_cnt_raw)
    );

    hdu_sat_cnt #(.WIDTH(CNT_W)) u_cntFlush (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (1'b0),
        .i_inc   (w_redirect & ~i_sram_stall),
        .o_count (o_cnt_flush)
    );

    hdu_sat_cnt #(.WIDTH(CNT_W)) u_cntSram (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (1'b0),
        .i_inc   (i_sram_stall),
        .o_count (o_cnt_sram)
    );
`else
    logic w_unusedRawStall;
    assign w_unusedRawStall = w_rawStall;
`endif

endmodule

// File: tb/tb_hdu_sb.sv
// ---------------------------------------------------------------------------
// tb_hdu_sb
// Directed self-checking bench for hdu_sb with default parameters
// (N_PREG=4, HAZ_DEPTH=3, BR_STAGE=2, TIMEOUT=1024), perf counters disabled.
// Control outputs are checked as one packed word {pc_wren, raw_stall,
// preg_wren[3:0], preg_clear[3:0]}.
// ---------------------------------------------------------------------------
module tb_hdu_sb;

    logic       clk = 1'b0;
    logic       reset;
    logic       sramStall;
    logic       pcsel;
    logic       isBr;
    logic       isUncbr;
    logic       idValid;
    logic       idRdwren;
    logic [4:0] idRd;
    logic [4:0] idRs1;
    logic [4:0] idRs2;
    logic       idRs1Used;
    logic       idRs2Used;
    logic       pcWren;
    logic [3:0] pregWren;
    logic [3:0] pregClear;
    logic       rawStall;
    logic       sramTimeout;

    int vectorCount = 0;
    int missCount   = 0;
    int freezeBad   = 0;

    // Expected control words {pc, raw, wren, clear}
    localparam logic [9:0] CTL_NORMAL = {1'b1, 1'b0, 4'b1111, 4'b0000};
    localparam logic [9:0] CTL_RAW    = {1'b0, 1'b1, 4'b1110, 4'b0010};
    localparam logic [9:0] CTL_FLUSH  = {1'b1, 1'b0, 4'b1111, 4'b0111};
    localparam logic [9:0] CTL_FREEZE = {1'b0, 1'b0, 4'b0000, 4'b0000};
    localparam logic [9:0] CTL_RESET  = {1'b0, 1'b0, 4'b1111, 4'b1111};

    always #5 clk = ~clk;

    hdu_sb dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_sram_stall   (sramStall),
        .i_pcsel        (pcsel),
        .i_is_br        (isBr),
        .i_is_uncbr     (isUncbr),
        .i_id_valid     (idValid),
        .i_id_rdwren    (idRdwren),
        .i_id_rd        (idRd),
        .i_id_rs1       (idRs1),
        .i_id_rs2       (idRs2),
        .i_id_rs1_used  (idRs1Used),
        .i_id_rs2_used  (idRs2Used),
        .o_pc_wren      (pcWren),
        .o_preg_wren    (pregWren),
        .o_preg_clear   (pregClear),
        .o_raw_stall    (rawStall),
        .o_sram_timeout (sramTimeout)
    );

    // Single comparison point: counts the vector and reports a miscompare.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives the instruction currently sitting in ID.
    task automatic applyStimulus(input logic v, input logic wr, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2);
        idValid   = v;
        idRdwren  = wr;
        idRd      = rd;
        idRs1     = rs1;
        idRs2     = rs2;
        idRs1Used = u1;
        idRs2Used = u2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkCtl(input string tag, input logic [9:0] expected);
        #1;
        checkOutput(tag, {22'd0, pcWren, rawStall, pregWren, pregClear}, {22'd0, expected});
    endtask

    initial begin
        reset     = 1'b1;
        sramStall = 1'b0;
        pcsel     = 1'b0;
        isBr      = 1'b0;
        isUncbr   = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checkCtl("reset outputs", CTL_RESET);
        reset = 1'b0;
        checkCtl("idle normal", CTL_NORMAL);
        checkOutput("timeout after reset", {31'd0, sramTimeout}, 32'd0);

        // add x5 ; add x6,x5,x1 -> three stall cycles
        applyStimulus(1, 1, 5, 2, 3, 1, 1);
        checkCtl("producer no stall", CTL_NORMAL);
        tick();
        applyStimulus(1, 1, 6, 5, 1, 1, 1);
        checkCtl("raw cycle 1", CTL_RAW);
        tick();
        checkCtl("raw cycle 2", CTL_RAW);
        tick();
        checkCtl("raw cycle 3", CTL_RAW);
        tick();
        checkCtl("raw released", CTL_NORMAL);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick(); tick(); tick();

        // x0 producer / x0 consumer
        applyStimulus(1, 1, 0, 1, 2, 1, 1);
        tick();
        applyStimulus(1, 1, 4, 0, 0, 1, 1);
        checkCtl("x0 no stall", CTL_NORMAL);
        tick();

        // rs2 unused, then used, then invalid ID
        applyStimulus(1, 1, 7, 1, 2, 1, 1);
        tick();
        applyStimulus(1, 1, 10, 3, 7, 1, 0);
        checkCtl("rs2 unused", CTL_NORMAL);
        applyStimulus(1, 1, 10, 3, 7, 1, 1);
        checkCtl("rs2 used", CTL_RAW);
        applyStimulus(0, 1, 10, 3, 7, 1, 1);
        checkCtl("id invalid", CTL_NORMAL);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick(); tick(); tick();

        // Producer at ID/EX flushed by a branch redirect
        applyStimulus(1, 1, 8, 1, 2, 1, 1);
        tick();
        applyStimulus(1, 1, 11, 8, 0, 1, 0);
        pcsel = 1'b1;
        isBr  = 1'b1;
        checkCtl("redirect beats raw", CTL_FLUSH);
        tick();
        pcsel = 1'b0;
        isBr  = 1'b0;
        checkCtl("dep after flush", CTL_NORMAL);
        pcsel   = 1'b1;
        isUncbr = 1'b1;
        checkCtl("jal redirect", CTL_FLUSH);
        isUncbr = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkCtl("pcsel without br", CTL_NORMAL);
        pcsel = 1'b0;
        tick(); tick(); tick();

        // SRAM freeze held for TIMEOUT cycles
        applyStimulus(1, 1, 9, 1, 2, 1, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        sramStall = 1'b1;
        checkCtl("sram freeze", CTL_FREEZE);
        for (int i = 0; i < 1023; i++) begin
            tick();
            if (pcWren !== 1'b0 || pregWren !== 4'b0000 || pregClear !== 4'b0000) begin
                freezeBad++;
            end
        end
        checkOutput("timeout at 1023", {31'd0, sramTimeout}, 32'd0);
        tick();
        checkOutput("timeout at 1024", {31'd0, sramTimeout}, 32'd1);
        checkOutput("freeze held", freezeBad, 32'd0);
        sramStall = 1'b0;
        applyStimulus(1, 1, 12, 9, 0, 1, 0);
        checkCtl("shadow held", CTL_RAW);
        checkOutput("timeout sticky", {31'd0, sramTimeout}, 32'd1);

        // Reset during a RAW stall
        tick();
        checkCtl("raw before reset", CTL_RAW);
        reset = 1'b1;
        checkCtl("reset forced", CTL_RESET);
        tick();
        reset = 1'b0;
        checkCtl("raw cleared by reset", CTL_NORMAL);
        checkOutput("timeout cleared", {31'd0, sramTimeout}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
